// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with burst limit and pre-emption for the shared word mux.
// Optional ARB_LOCK_EN adds a lock input that suppresses pre-emption.
module bus_arbiter #(
    parameter int N_REQ     = 4,
    parameter int SEL_W     = 2,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
`ifdef ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [SEL_W:0]     start;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   win;
    logic [N_REQ-1:0]   win_oh;
    int                 off;
    int                 widx;
    logic               cur_hi, others, at_max, hold_lock;

    // rot[k] is the request at position (last+1+k) mod N_REQ
    assign start  = {1'b0, last_q} + (SEL_W+1)'(1);
    assign rot    = N_REQ'({req, req} >> start);
    assign win_oh = N_REQ'(1) << win;

    always_comb begin
        off = 0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            if (rot[k]) off = k;
        end
        widx = int'(start) + off;
        if (widx >= N_REQ) widx = widx - N_REQ;
        win = SEL_W'(widx);
    end

    assign cur_hi = |(req & grant_q);
    assign others = |(req & ~grant_q);
    assign at_max = (count_q == CNT_W'(MAX_BURST));
`ifdef ARB_LOCK_EN
    assign hold_lock = lock;
`else
    assign hold_lock = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= SEL_W'(N_REQ-1);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    grant_d = win_oh;
                    sel_d   = win;
                    last_d  = win;
                    count_d = CNT_W'(1);
                end
            end
            default: begin
                if (cur_hi && !(at_max && others && !hold_lock)) begin
                    if (!at_max) count_d = count_q + CNT_W'(1);
                end else if (others) begin
                    // hand over directly; the search already skips the releasing requester
                    grant_d = win_oh;
                    sel_d   = win;
                    last_d  = win;
                    count_d = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    count_d = '0;
                end
            end
        endcase
    end

    always_comb begin
        grant = grant_q;
        sel   = sel_q;
        busy  = (state_q == GRANT);
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: expected grant/sel/busy are queued when stimulus
// is driven and compared one clock later.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
`ifdef ARB_LOCK_EN
    logic       lock = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bus_arbiter #(.N_REQ(4), .SEL_W(2), .MAX_BURST(8), .CNT_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
`ifdef ARB_LOCK_EN
        .lock    (lock),
`endif
        .grant   (grant),
        .sel     (sel),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic cyc(input string tag, input logic [3:0] g, input logic [1:0] s, input logic b);
        exp_t e;
        exp_q.push_back('{g: g, s: s, b: b});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        assert (grant === e.g) else begin
            errors++;
            $error("FAIL %s grant: got %b want %b", tag, grant, e.g);
        end
        checks++;
        assert (sel === e.s) else begin
            errors++;
            $error("FAIL %s sel: got %0d want %0d", tag, sel, e.s);
        end
        checks++;
        assert (busy === e.b) else begin
            errors++;
            $error("FAIL %s busy: got %b want %b", tag, busy, e.b);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 4'b0000;
        cyc("reset0", 4'b0000, 2'd0, 1'b0);
        cyc("reset1", 4'b0000, 2'd0, 1'b0);
        reset_n = 1'b1;
        cyc("idle", 4'b0000, 2'd0, 1'b0);

        // single requester held well past the burst limit
        req = 4'b0001;
        for (int i = 0; i < 20; i++) cyc("hold0", 4'b0001, 2'd0, 1'b1);
        // count saturated, so a new requester pre-empts on the very next edge
        req = 4'b0011;
        cyc("sat_preempt", 4'b0010, 2'd1, 1'b1);
        req = 4'b0000;
        cyc("release_idle", 4'b0000, 2'd1, 1'b0);

        // full rotation under constant contention
        reset_n = 1'b0;
        req     = 4'b1111;
        cyc("reset_rr", 4'b0000, 2'd0, 1'b0);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++)
            for (int c = 0; c < 8; c++)
                cyc("rr", 4'b0001 << (k % 4), 2'(k % 4), 1'b1);
        for (int c = 0; c < 3; c++) cyc("rr5", 4'b0010, 2'd1, 1'b1);

        // reset mid-burst
        reset_n = 1'b0;
        cyc("reset_mid", 4'b0000, 2'd0, 1'b0);
        reset_n = 1'b1;
        cyc("after_reset", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        cyc("drop0", 4'b0000, 2'd0, 1'b0);

        // drop granted req while another waits: no bubble
        req = 4'b1010;
        for (int c = 0; c < 3; c++) cyc("g1", 4'b0010, 2'd1, 1'b1);
        req = 4'b1000;
        cyc("handoff3", 4'b1000, 2'd3, 1'b1);
        req = 4'b0000;
        cyc("idle_sel3", 4'b0000, 2'd3, 1'b0);

        // drop with nothing pending: sel holds
        req = 4'b0100;
        cyc("g2a", 4'b0100, 2'd2, 1'b1);
        cyc("g2b", 4'b0100, 2'd2, 1'b1);
        req = 4'b0000;
        cyc("idle_sel2a", 4'b0000, 2'd2, 1'b0);
        cyc("idle_sel2b", 4'b0000, 2'd2, 1'b0);

        // drop and raise in the same cycle
        req = 4'b0001;
        cyc("g0", 4'b0001, 2'd0, 1'b1);
        req = 4'b0010;
        cyc("swap", 4'b0010, 2'd1, 1'b1);
        req = 4'b0000;
        cyc("idle_sel1", 4'b0000, 2'd1, 1'b0);

        // non-granted req changes do not disturb an unexpired burst
        req = 4'b0100;
        cyc("g2c", 4'b0100, 2'd2, 1'b1);
        req = 4'b0101;
        cyc("noise1", 4'b0100, 2'd2, 1'b1);
        req = 4'b1100;
        cyc("noise2", 4'b0100, 2'd2, 1'b1);
        req = 4'b0000;
        cyc("idle_end", 4'b0000, 2'd2, 1'b0);

`ifdef ARB_LOCK_EN
        reset_n = 1'b0;
        cyc("reset_lock", 4'b0000, 2'd0, 1'b0);
        reset_n = 1'b1;
        req  = 4'b0011;
        lock = 1'b1;
        for (int c = 0; c < 28; c++) cyc("locked", 4'b0001, 2'd0, 1'b1);
        lock = 1'b0;
        cyc("unlock", 4'b0010, 2'd1, 1'b1);
        req = 4'b0000;
        cyc("lock_idle", 4'b0000, 2'd1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
